// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction prefetch unit. Issues single-outstanding read requests to
// instruction memory, buffers returned words (tagged with their word address)
// in a small FIFO, and presents the FIFO head to the control unit. A branch
// redirect flushes the FIFO and restarts fetching at the target; a request
// already in flight when the redirect arrives is completed and its data
// discarded.
//
// Configuration macro: FETCH_BYPASS_EN
//   undefined (default): instr_* outputs are decoded from registered state
//                        only; returned data is visible one cycle after mem_ack.
//   defined            : with the FIFO empty, mem_data is forwarded to instr_out
//                        in the mem_ack cycle and may be consumed directly.
//
// Parameters
//   DEPTH         FIFO entries (power of two, 2..8)
//   RESET_VECTOR  word address of the first fetch after reset
//   BUBBLE        instr_out value while no instruction is available
//
// Ports
//   clock          in   single clock, rising edge
//   reset          in   synchronous, active-high reset
//   mem_req        out  read request to instruction memory
//   mem_addr       out  word address of the pending request (fetch_pc when idle)
//   mem_ack        in   memory completes the request; mem_data valid
//   mem_data       in   fetched instruction word
//   instr_out      out  FIFO head
//   instr_valid    out  instr_out holds a real instruction
//   instr_pc       out  word address of instr_out (fetch_pc when empty)
//   enable         in   consumer accepts instr_out this cycle
//   branch_taken   in   redirect request
//   branch_target  in   redirect word address
//   fifo_count     out  current FIFO occupancy
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int unsigned DEPTH        = 4,
    parameter logic [15:0] RESET_VECTOR = 16'h0000,
    parameter logic [15:0] BUBBLE       = 16'h0000
) (
    input  logic                     clock,
    input  logic                     reset,
    output logic                     mem_req,
    output logic [15:0]              mem_addr,
    input  logic                     mem_ack,
    input  logic [15:0]              mem_data,
    output logic [15:0]              instr_out,
    output logic                     instr_valid,
    output logic [15:0]              instr_pc,
    input  logic                     enable,
    input  logic                     branch_taken,
    input  logic [15:0]              branch_target,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,   // no request outstanding
        REQ,    // request outstanding, data will be kept
        DROP    // request outstanding, data will be discarded (redirected)
    } fetchStateT;

    fetchStateT      state, stateNext;
    logic [15:0]     fetchPc, fetchPcNext;
    logic [15:0]     reqAddr;
    logic [PtrW-1:0] rdPtr, wrPtr;
    logic [CntW-1:0] count;
    logic [15:0]     dataMem [DEPTH];
    logic [15:0]     pcMem   [DEPTH];

    logic            fifoEmpty, popFifo, ackData, pushFifo;
    logic [CntW-1:0] countAfter;

    assign fifoEmpty  = (count == '0);
    assign popFifo    = enable && !fifoEmpty;
    // Returned word that is to be kept (a redirect in the same cycle drops it).
    assign ackData    = (state == REQ) && mem_ack && !branch_taken;

`ifdef FETCH_BYPASS_EN
    logic bypassHit;
    assign bypassHit   = fifoEmpty && ackData;
    // A forwarded word accepted in the same cycle never enters the FIFO.
    assign pushFifo    = ackData && !(bypassHit && enable);
    assign instr_valid = !fifoEmpty || bypassHit;
    assign instr_out   = !fifoEmpty ? dataMem[rdPtr] : (bypassHit ? mem_data : BUBBLE);
    assign instr_pc    = !fifoEmpty ? pcMem[rdPtr] : fetchPc;
`else
    assign pushFifo    = ackData;
    assign instr_valid = !fifoEmpty;
    assign instr_out   = fifoEmpty ? BUBBLE : dataMem[rdPtr];
    assign instr_pc    = fifoEmpty ? fetchPc : pcMem[rdPtr];
`endif

    // Occupancy at the end of this cycle, ignoring a flush.
    assign countAfter = count + CntW'(pushFifo) - CntW'(popFifo);

    assign mem_req    = (state != IDLE);
    assign mem_addr   = reqAddr;
    assign fifo_count = count;

    // NOTE: every variable gets a default before the case so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        stateNext   = state;
        fetchPcNext = fetchPc;
        unique case (state)
            IDLE: begin
                if (branch_taken) begin
                    fetchPcNext = branch_target;
                end else if (countAfter < DepthC) begin
                    // Room for the word this request will return.
                    stateNext = REQ;
                end
            end
            REQ: begin
                if (branch_taken) begin
                    fetchPcNext = branch_target;
                    stateNext   = mem_ack ? IDLE : DROP;
                end else if (mem_ack) begin
                    fetchPcNext = fetchPc + 16'd1;
                    stateNext   = (countAfter < DepthC) ? REQ : IDLE;
                end
            end
            DROP: begin
                if (branch_taken) begin
                    fetchPcNext = branch_target;
                end
                if (mem_ack) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            fetchPc <= RESET_VECTOR;
            reqAddr <= RESET_VECTOR;
            rdPtr   <= '0;
            wrPtr   <= '0;
            count   <= '0;
        end else begin
            state   <= stateNext;
            fetchPc <= fetchPcNext;
            // The address is frozen while a discarded request completes.
            if (stateNext != DROP) begin
                reqAddr <= fetchPcNext;
            end
            if (branch_taken) begin
                rdPtr <= '0;
                wrPtr <= '0;
                count <= '0;
            end else begin
                if (pushFifo) begin
                    wrPtr <= wrPtr + PtrW'(1);
                end
                if (popFifo) begin
                    rdPtr <= rdPtr + PtrW'(1);
                end
                count <= countAfter;
            end
        end
    end

    // NOTE: storage is not reset; pointers and count alone decide what is
    // valid, so stale entries are never observed.
    always_ff @(posedge clock) begin
        if (pushFifo) begin
            dataMem[wrPtr] <= mem_data;
            pcMem[wrPtr]   <= fetchPc;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Self-checking bench for fetch_unit (default build, FETCH_BYPASS_EN
// undefined). A transaction-level model (queue of {pc,data} plus a pending
// request flag and a discard flag) predicts every output after each edge.
// Directed phases cover reset, sequential fetch with address wrap, FIFO fill
// and refill, redirect during an outstanding request, redirect coinciding with
// mem_ack, randomized traffic, and reset in mid-request.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam int unsigned DEPTH = 4;
    localparam logic [15:0] RV    = 16'hFFFE;
    localparam logic [15:0] BUB   = 16'hB0B0;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_data = '0;
    logic [15:0] instr_out;
    logic        instr_valid;
    logic [15:0] instr_pc;
    logic        enable = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_target = '0;
    logic [2:0]  fifo_count;

    fetch_unit #(
        .DEPTH(DEPTH),
        .RESET_VECTOR(RV),
        .BUBBLE(BUB)
    ) dut (
        .clock(clock),
        .reset(reset),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .mem_ack(mem_ack),
        .mem_data(mem_data),
        .instr_out(instr_out),
        .instr_valid(instr_valid),
        .instr_pc(instr_pc),
        .enable(enable),
        .branch_taken(branch_taken),
        .branch_target(branch_target),
        .fifo_count(fifo_count)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] data;
    } entryT;

    // Reference model state
    entryT       mq[$];
    logic [15:0] mPc = RV;
    logic [15:0] mPendAddr = RV;
    bit          mPending = 1'b0;
    bit          mDropping = 1'b0;

    // Instructions actually handed out by the DUT
    entryT       dutPops[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance the model across one clock edge with the given inputs.
    task automatic modelEdge(input logic rst, input logic en, input logic ack,
                             input logic [15:0] data, input logic br,
                             input logic [15:0] tgt);
        if (rst) begin
            mq.delete();
            mPc       = RV;
            mPendAddr = RV;
            mPending  = 1'b0;
            mDropping = 1'b0;
            return;
        end
        if (en && mq.size() > 0) begin
            void'(mq.pop_front());
        end
        if (br) begin
            mq.delete();
            mPc = tgt;
            if (mPending) begin
                if (ack) begin
                    mPending  = 1'b0;
                    mDropping = 1'b0;
                end else begin
                    mDropping = 1'b1;
                end
            end
        end else if (mPending) begin
            if (ack) begin
                if (!mDropping) begin
                    mq.push_back({mPendAddr, data});
                    mPc       = mPc + 16'd1;
                    mPending  = (mq.size() < DEPTH);
                    mPendAddr = mPc;
                end else begin
                    mPending = 1'b0;
                end
                mDropping = 1'b0;
            end
        end else if (mq.size() < DEPTH) begin
            mPending  = 1'b1;
            mPendAddr = mPc;
        end
    endtask

    task automatic compareAll();
        logic [15:0] eOut;
        logic [15:0] ePc;
        eOut = (mq.size() > 0) ? mq[0].data : BUB;
        ePc  = (mq.size() > 0) ? mq[0].pc   : mPc;
        check("instr_valid", 32'(instr_valid), 32'(mq.size() > 0));
        check("instr_out",   32'(instr_out),   32'(eOut));
        check("instr_pc",    32'(instr_pc),    32'(ePc));
        check("mem_req",     32'(mem_req),     32'(mPending));
        check("mem_addr",    32'(mem_addr),    32'(mPending ? mPendAddr : mPc));
        check("fifo_count",  32'(fifo_count),  32'(mq.size()));
    endtask

    // One clock cycle: drive inputs, record a DUT pop, step the model,
    // then compare all outputs 1 time unit after the edge.
    task automatic step(input logic rst, input logic en, input logic ack,
                        input logic [15:0] data, input logic br,
                        input logic [15:0] tgt);
        reset         = rst;
        enable        = en;
        mem_ack       = ack;
        mem_data      = data;
        branch_taken  = br;
        branch_target = tgt;
        if (!rst && en && instr_valid === 1'b1) begin
            dutPops.push_back({instr_pc, instr_out});
        end
        modelEdge(rst, en, ack, data, br, tgt);
        @(posedge clock);
        #1;
        compareAll();
    endtask

    initial begin
        logic        a, e, b;
        logic [15:0] t, d;
        int          waitCycles;

        // ---- Reset, with a stray mem_ack while reset is high ----
        step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        step(1'b1, 1'b1, 1'b1, 16'h1111, 1'b0, 16'h0);
        step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'(RV));
        check("rst_instr_out", 32'(instr_out), 32'(BUB));
        check("rst_instr_pc", 32'(instr_pc), 32'(RV));
        check("rst_count", 32'(fifo_count), 32'd0);

        // ---- First cycle after reset: ack ignored, request rises at the edge ----
        step(1'b0, 1'b1, 1'b1, 16'h1234, 1'b0, 16'h0);
        check("first_req", 32'(mem_req), 32'd1);
        check("first_addr", 32'(mem_addr), 32'(RV));
        check("first_empty", 32'(fifo_count), 32'd0);

        // ---- Sequential fetch, ack one cycle after request, data A000+addr ----
        waitCycles = 0;
        dutPops.delete();
        for (int i = 0; i < 16; i++) begin
            a = 1'b0;
            if (mPending) begin
                if (waitCycles == 1) begin
                    a = 1'b1;
                    waitCycles = 0;
                end else begin
                    waitCycles++;
                end
            end
            d = 16'hA000 + mPendAddr;
            step(1'b0, 1'b1, a, d, 1'b0, 16'h0);
        end
        check("seq_len", 32'(dutPops.size() >= 3), 32'd1);
        if (dutPops.size() >= 3) begin
            check("seq0_pc",   32'(dutPops[0].pc),   32'h0000_FFFE);
            check("seq0_data", 32'(dutPops[0].data), 32'h0000_9FFE);
            check("seq1_pc",   32'(dutPops[1].pc),   32'h0000_FFFF);
            check("seq1_data", 32'(dutPops[1].data), 32'h0000_9FFF);
            check("seq2_pc",   32'(dutPops[2].pc),   32'h0000_0000);
            check("seq2_data", 32'(dutPops[2].data), 32'h0000_A000);
        end

        // ---- Fill with enable=0 and immediate acks ----
        for (int i = 0; i < 10; i++) begin
            d = 16'h5000 + mPendAddr;
            step(1'b0, 1'b0, mPending, d, 1'b0, 16'h0);
        end
        check("full_count", 32'(fifo_count), 32'(DEPTH));
        check("full_no_req", 32'(mem_req), 32'd0);
        step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
        check("refill_req", 32'(mem_req), 32'd1);
        check("refill_count", 32'(fifo_count), 32'(DEPTH - 1));
        step(1'b0, 1'b0, 1'b1, 16'h7777, 1'b0, 16'h0);
        check("refill_full", 32'(fifo_count), 32'(DEPTH));
        step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        check("refill_one_req", 32'(mem_req), 32'd0);

        // ---- Redirect while request to 5 is outstanding, ack 3 cycles later ----
        step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h0005);
        check("flush_valid", 32'(instr_valid), 32'd0);
        step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        check("req5_addr", 32'(mem_addr), 32'h0005);
        step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h0040);
        check("drop_req", 32'(mem_req), 32'd1);
        check("drop_addr", 32'(mem_addr), 32'h0005);
        step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
        step(1'b0, 1'b1, 1'b1, 16'hBEEF, 1'b0, 16'h0);
        check("drop_addr_next", 32'(mem_addr), 32'h0040);
        check("drop_no_valid", 32'(instr_valid), 32'd0);
        step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        check("req40_addr", 32'(mem_addr), 32'h0040);
        check("req40_no_valid", 32'(instr_valid), 32'd0);

        // ---- Redirect coinciding with mem_ack in REQ ----
        step(1'b0, 1'b0, 1'b1, 16'hCAFE, 1'b1, 16'h0100);
        check("brack_idle", 32'(mem_req), 32'd0);
        check("brack_count", 32'(fifo_count), 32'd0);
        step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        check("brack_next_addr", 32'(mem_addr), 32'h0100);

        // ---- Randomized traffic ----
        for (int i = 0; i < 2000; i++) begin
            e = ($urandom_range(0, 3) != 0);
            a = mPending && ($urandom_range(0, 2) == 0);
            b = ($urandom_range(0, 24) == 0);
            t = 16'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                t = 16'hFFFC + 16'($urandom_range(0, 3));
            end
            d = 16'($urandom);
            step(1'b0, e, a, d, b, t);
        end

        // ---- Reset in the middle of a request ----
        for (int i = 0; i < 20 && !mPending; i++) begin
            step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
        end
        check("reach_req", 32'(mem_req), 32'd1);
        step(1'b1, 1'b0, 1'b1, 16'hDEAD, 1'b0, 16'h0);
        check("midrst_req", 32'(mem_req), 32'd0);
        check("midrst_count", 32'(fifo_count), 32'd0);
        check("midrst_addr", 32'(mem_addr), 32'(RV));
        step(1'b0, 1'b0, 1'b1, 16'hDEAD, 1'b0, 16'h0);
        check("midrst_after_count", 32'(fifo_count), 32'd0);
        step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
